// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Front end of the RV32I minimum core. Owns the program counter. Issues one
// instruction-memory read at a time and presents the fetched word, with its
// PC, to decode/ALU. Takes branch/jump redirects from the ALU. A misaligned
// redirect target latches a sticky fault, and the block then stays idle
// until reset.
//
// Ports
//   clock, reset          single clock; synchronous active-high reset
//   imem_req_valid/ready  fetch request handshake
//   imem_req_addr         fetch byte address (always equals pc)
//   imem_rsp_valid/data   single-cycle read response (no backpressure)
//   instr_valid/ready     instruction handshake toward decode/ALU
//   instruction, pc       fetched word and its address
//   next_pc_valid/next_pc ALU redirect, sampled only in the handshake cycle
//   misaligned_fault      sticky flag for a redirect with next_pc[1:0] != 0
//   fault_pc              offending redirect target
//   retired_count         number of instruction handshakes (wrapping)
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    input  logic        next_pc_valid,
    input  logic [31:0] next_pc,
    output logic        misaligned_fault,
    output logic [31:0] fault_pc,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT_RSP,
        ST_HOLD,
        ST_FAULT
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   handshake;
    logic   redirect_bad;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    // The address is simply the PC. The PC only moves on a handshake, so the
    // address stays stable for as long as the request waits for acceptance.
    assign imem_req_addr = pc;

    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        handshake      = 1'b0;
        redirect_bad   = next_pc_valid && is_misaligned(next_pc);
        case (state)
            ST_REQ: begin
                // Both valids are masked by reset so nothing leaks out while
                // the core is held in reset.
                imem_req_valid = !reset;
                if (imem_req_ready) begin
                    state_nxt = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (imem_rsp_valid) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                instr_valid = !reset;
                handshake   = instr_valid && instr_ready;
                if (handshake) begin
                    state_nxt = redirect_bad ? ST_FAULT : ST_REQ;
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= ST_REQ;
            pc               <= RESET_PC;
            instruction      <= 32'h0000_0000;
            retired_count    <= 32'h0000_0000;
            misaligned_fault <= 1'b0;
            fault_pc         <= 32'h0000_0000;
        end else begin
            state <= state_nxt;
            // Responses outside WAIT_RSP are strays and are dropped.
            if (state == ST_WAIT_RSP && imem_rsp_valid) begin
                instruction <= imem_rsp_data;
            end
            if (handshake) begin
                retired_count <= retired_count + 32'd1;
                if (!next_pc_valid) begin
                    pc <= pc + 32'd4;
                end else if (!redirect_bad) begin
                    pc <= next_pc;
                end else begin
                    // pc keeps the faulting instruction's address.
                    fault_pc         <= next_pc;
                    misaligned_fault <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        next_pc_valid;
    logic [31:0] next_pc;
    logic        misaligned_fault;
    logic [31:0] fault_pc;
    logic [31:0] retired_count;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clock            (clock),
        .reset            (reset),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instruction      (instruction),
        .pc               (pc),
        .next_pc_valid    (next_pc_valid),
        .next_pc          (next_pc),
        .misaligned_fault (misaligned_fault),
        .fault_pc         (fault_pc),
        .retired_count    (retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] exp_count  = 32'h0;
    int          accept_cyc = 0;

    typedef struct {
        int          rdy_dly;
        int          rsp_dly;
        int          stall;
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] exp_addr;
        logic        preload;
    } vec_t;

    vec_t tbl[9];

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One complete fetch, entered and left just after a falling edge.
    task automatic fetch(input int rdy_dly, input int rsp_dly, input int stall,
                         input logic redir, input logic [31:0] tgt,
                         input logic [31:0] exp_addr, input logic preload);
        int n;
        n = 0;
        while (!imem_req_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("req_addr", imem_req_addr, exp_addr);
        chk("no_instr_in_req", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < rdy_dly; i++) begin
            // A stray response while the request waits must be ignored.
            imem_rsp_valid = (i == 0);
            imem_rsp_data  = ~mem_word(exp_addr);
            @(negedge clock);
            imem_rsp_valid = 1'b0;
            chk("addr_held", imem_req_addr, exp_addr);
            chk("req_valid_held", {31'b0, imem_req_valid}, 32'd1);
        end
        imem_req_ready = 1'b1;
        @(negedge clock);
        imem_req_ready = 1'b0;
        accept_cyc = cyc;
        chk("one_outstanding", {31'b0, imem_req_valid}, 32'd0);
        for (int i = 0; i < rsp_dly; i++) begin
            @(negedge clock);
            chk("wait_no_instr", {31'b0, instr_valid}, 32'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(exp_addr);
        @(negedge clock);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (preload) begin
            force dut.retired_count = 32'hFFFF_FFFF;
            #1;
            release dut.retired_count;
            exp_count = 32'hFFFF_FFFF;
        end
        chk("instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("instruction", instruction, mem_word(exp_addr));
        chk("pc", pc, exp_addr);
        for (int i = 0; i < stall; i++) begin
            // Redirect inputs outside the handshake cycle must be ignored.
            next_pc_valid = 1'b1;
            next_pc       = 32'h0000_0003;
            instr_ready   = 1'b0;
            @(negedge clock);
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_instr", instruction, mem_word(exp_addr));
            chk("stall_pc", pc, exp_addr);
            chk("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
            chk("stall_count", retired_count, exp_count);
        end
        instr_ready   = 1'b1;
        next_pc_valid = redir;
        next_pc       = tgt;
        @(negedge clock);
        instr_ready   = 1'b0;
        next_pc_valid = 1'b0;
        exp_count     = exp_count + 32'd1;
        chk("retired_count", retired_count, exp_count);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("rst_req_masked", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_instr_masked", {31'b0, instr_valid}, 32'd0);
        reset = 1'b0;
        #1;
        exp_count = 32'h0;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_count", retired_count, 32'h0);
        chk("rst_fault", {31'b0, misaligned_fault}, 32'd0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rst_req_addr", imem_req_addr, 32'h0);
    endtask

    initial begin
        logic [31:0] model_pc;
        logic        redir;
        logic [31:0] tgt;
        int          n;

        tbl[0] = '{0, 0, 0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[1] = '{0, 0, 0, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0};
        tbl[2] = '{0, 0, 5, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b0};
        tbl[3] = '{0, 0, 0, 1'b1, 32'h0000_0010, 32'h0000_000C, 1'b0};
        tbl[4] = '{0, 0, 0, 1'b1, 32'h0000_0100, 32'h0000_0010, 1'b0};
        tbl[5] = '{3, 4, 0, 1'b0, 32'h0000_0000, 32'h0000_0100, 1'b0};
        tbl[6] = '{0, 1, 2, 1'b1, 32'hFFFF_FFFC, 32'h0000_0104, 1'b0};
        tbl[7] = '{0, 0, 0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0};
        tbl[8] = '{0, 0, 0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1};

        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b0;
        next_pc_valid  = 1'b0;
        next_pc        = 32'h0;
        @(negedge clock);
        do_reset();

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            fetch(tbl[i].rdy_dly, tbl[i].rsp_dly, tbl[i].stall, tbl[i].redir,
                  tbl[i].tgt, tbl[i].exp_addr, tbl[i].preload);
            if (i == 2) chk("count_after_3", retired_count, 32'd3);
        end

        // Back-to-back zero-wait instructions: acceptances 3 cycles apart.
        begin
            int a0;
            fetch(0, 0, 0, 1'b0, 32'h0, 32'h0000_0004, 1'b0);
            a0 = accept_cyc;
            fetch(0, 0, 0, 1'b0, 32'h0, 32'h0000_0008, 1'b0);
            chk("throughput", accept_cyc - a0, 32'd3);
        end

        // Randomized phase against the address-sequence model.
        model_pc = 32'h0000_000C;
        for (int i = 0; i < 40; i++) begin
            redir = ($urandom_range(0, 3) == 0);
            tgt   = $urandom & 32'hFFFF_FFFC;
            fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  redir, tgt, model_pc, 1'b0);
            model_pc = redir ? tgt : model_pc + 32'd4;
        end

        // Misaligned redirect: sticky fault, terminal idle state.
        fetch(0, 0, 0, 1'b1, 32'h0000_0102, model_pc, 1'b0);
        chk("fault_flag", {31'b0, misaligned_fault}, 32'd1);
        chk("fault_pc", fault_pc, 32'h0000_0102);
        chk("fault_pc_unchanged", pc, model_pc);
        for (int i = 0; i < 5; i++) begin
            instr_ready    = 1'b1;
            imem_req_ready = 1'b1;
            imem_rsp_valid = (i == 1);
            @(negedge clock);
            chk("fault_no_req", {31'b0, imem_req_valid}, 32'd0);
            chk("fault_no_instr", {31'b0, instr_valid}, 32'd0);
            chk("fault_sticky", {31'b0, misaligned_fault}, 32'd1);
            chk("fault_count_frozen", retired_count, exp_count);
        end
        instr_ready    = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        do_reset();

        // Reset in HOLD beats a simultaneous handshake and redirect.
        imem_req_ready = 1'b1;
        @(negedge clock);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clock);
        imem_rsp_valid = 1'b0;
        chk("hold_before_reset", {31'b0, instr_valid}, 32'd1);
        instr_ready   = 1'b1;
        next_pc_valid = 1'b1;
        next_pc       = 32'h0000_0200;
        reset         = 1'b1;
        @(negedge clock);
        chk("midrst_instr_masked", {31'b0, instr_valid}, 32'd0);
        chk("midrst_count", retired_count, 32'h0);
        chk("midrst_instruction", instruction, 32'h0);
        chk("midrst_pc", pc, 32'h0);
        reset         = 1'b0;
        instr_ready   = 1'b0;
        next_pc_valid = 1'b0;
        exp_count     = 32'h0;
        #1;
        chk("midrst_req_addr", imem_req_addr, 32'h0);
        fetch(0, 1, 0, 1'b0, 32'h0, 32'h0, 1'b0);

        n = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Upstream neighbour of the execute/ALU stage in the RV32I minimum core.
- Owns the program counter and issues one instruction-memory read at a time over a valid/ready request with a valid-only response.
- Presents the fetched instruction and its PC to decode/ALU through a valid/ready handshake.
- Accepts the ALU's next_pc_valid/next_pc redirect for branches and jumps, and raises a sticky fault on a misaligned target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
clock  input  1  single core clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts the request
imem_req_addr  output  32  fetch byte address (equals pc)
imem_rsp_valid  input  1  read data valid (single-cycle pulse)
imem_rsp_data  input  32  read data
instr_valid  output  1  instruction/pc valid toward decode/ALU
instr_ready  input  1  decode/ALU consumes instruction this cycle
instruction  output  32  fetched instruction word
pc  output  32  address of the presented instruction
next_pc_valid  input  1  ALU redirect request (branch taken/jal/jalr)
next_pc  input  32  ALU redirect target
misaligned_fault  output  1  sticky: redirect target had next_pc[1:0] != 0
fault_pc  output  32  offending redirect target, captured on fault
retired_count  output  32  count of instruction handshakes

Behaviour:
- FSM states: REQ, WAIT_RSP, HOLD, FAULT.
- Reset (sampled at clock edge while reset=1):
  - state=REQ, pc=RESET_PC, instruction=0, retired_count=0, misaligned_fault=0, fault_pc=0.
  - imem_req_valid and instr_valid are forced 0 while reset=1.
- Instruction memory shares this reset. Responses in flight across reset are illegal stimulus.
- REQ:
  - Drive imem_req_valid=1, imem_req_addr=pc.
  - imem_req_valid&&imem_req_ready -> WAIT_RSP.
  - Address is held stable until accepted.
- WAIT_RSP:
  - imem_req_valid=0.
  - imem_rsp_valid=1 -> instruction<=imem_rsp_data, go to HOLD.
  - The earliest legal response is the cycle after acceptance.
  - imem_rsp_valid in any other state is ignored.
- HOLD:
  - instr_valid=1; instruction and pc are held stable until the handshake.
  - Handshake = instr_valid&&instr_ready.
  - On handshake, retired_count increments (wraps 0xFFFF_FFFF -> 0).
  - next_pc_valid/next_pc are sampled only in the handshake cycle; at any other time they are ignored.
- Next-PC selection on handshake:
  - next_pc_valid=0: pc<=pc+4 (mod 2^32; 0xFFFF_FFFC wraps to 0), go to REQ.
  - next_pc_valid=1 and next_pc[1:0]==0: pc<=next_pc, go to REQ.
  - next_pc_valid=1 and next_pc[1:0]!=0: fault_pc<=next_pc, misaligned_fault<=1, go to FAULT; pc is unchanged.
- FAULT:
  - Terminal until reset; no requests issued, instr_valid=0.
  - misaligned_fault is held at 1 and retired_count is frozen.
- Throughput:
  - Minimum of 3 cycles per instruction (REQ, WAIT_RSP, HOLD) with zero-wait memory and instr_ready=1.
  - Only one request is outstanding at any time.
- Reset mid-operation (in any state): returns to REQ at RESET_PC on the next edge; the captured instruction is discarded.
- Reset has priority over every other event in the same cycle.

Test Plan:
1. Reset, then memory always ready with 1-cycle response, instr_ready=1 -> requests at 0x0, 0x4, 0x8, one every 3 cycles; retired_count=3 after the third handshake.
2. Hold instr_ready=0 for 5 cycles in HOLD -> instr_valid stays 1, instruction/pc stable, no new imem request, retired_count unchanged.
3. At handshake for pc=0x10, assert next_pc_valid=1, next_pc=0x100 -> next imem_req_addr=0x100; without assertion it would be 0x14.
4. Redirect next_pc=0x102 -> misaligned_fault=1, fault_pc=0x102, no further requests; assert reset -> fault clears, request at RESET_PC.
5. Delay imem_req_ready by 3 cycles and the response by 4 cycles; pulse imem_rsp_valid while in REQ -> address held stable, stray response ignored, correct instruction captured.
6. Preload pc=0xFFFF_FFFC via redirect and handshake without redirect -> next request addr=0x0; preload retired_count=0xFFFF_FFFF (force) -> wraps to 0.
